// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: FSM states and ALU opcodes.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters, the arbiter and the result consumer.
interface alu_arbiter_if #(parameter int N = 8) ();

    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [2:0]   req0_sel;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req1_sel;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N:0]   rsp_q;
    logic         rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_q, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_q, rsp_err
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters; outputs are forced to zero when disabled.
module ALU
    import alu_arb_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         i_en,
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic [2:0]   i_sel,
    output logic [n:0]   o_q,
    output logic         o_err
);

    logic [n-1:0] w_res;
    logic         w_err;

    // Results are kept to n bits; the extra result bit is always zero.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        if (i_en) begin
            case (i_sel)
                OP_ADD:  w_res = i_a + i_b;
                OP_SUB:  w_res = i_a - i_b;
                OP_MUL:  w_res = i_a * i_b;
                OP_DIV: begin
                    if (i_b == '0) begin
                        w_err = 1'b1;
                    end else begin
                        w_res = i_a / i_b;
                    end
                end
                OP_AND:  w_res = i_a & i_b;
                OP_OR:   w_res = i_a | i_b;
                OP_XOR:  w_res = i_a ^ i_b;
                OP_NOR:  w_res = ~(i_a | i_b);
                default: w_res = '0;
            endcase
        end
    end

    assign o_q   = {1'b0, w_res};
    assign o_err = w_err;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: grant in IDLE, compute in EXEC, hold result in RESP.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_t       r_state;
    logic         r_prio;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [2:0]   r_sel;
    logic         r_id;
    logic [N:0]   r_q;
    logic         r_err;

    state_t       w_next;
    logic         w_grant;
    logic         w_grantValid;
    logic         w_rdy0;
    logic         w_rdy1;
    logic         w_aluEn;
    logic [N:0]   w_aluQ;
    logic         w_aluErr;

    ALU #(.n(N)) u_alu (
        .i_en  (w_aluEn),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_sel (r_sel),
        .o_q   (w_aluQ),
        .o_err (w_aluErr)
    );

    // Ready depends on valid, never the reverse; grant only in IDLE.
    always_comb begin
        w_next       = r_state;
        w_grant      = 1'b0;
        w_grantValid = 1'b0;
        w_rdy0       = 1'b0;
        w_rdy1       = 1'b0;
        w_aluEn      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    w_grantValid = 1'b1;
                    w_grant      = r_prio;
                end else if (bus.req0_valid) begin
                    w_grantValid = 1'b1;
                    w_grant      = 1'b0;
                end else if (bus.req1_valid) begin
                    w_grantValid = 1'b1;
                    w_grant      = 1'b1;
                end
                w_rdy0 = w_grantValid && !w_grant;
                w_rdy1 = w_grantValid && w_grant;
                if (w_grantValid) begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                w_aluEn = 1'b1;
                w_next  = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            w_rdy0 = 1'b0;
            w_rdy1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= OP_ADD;
            r_id    <= 1'b0;
            r_q     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_a   <= w_grant ? bus.req1_a   : bus.req0_a;
                        r_b   <= w_grant ? bus.req1_b   : bus.req0_b;
                        r_sel <= w_grant ? bus.req1_sel : bus.req0_sel;
                        r_id  <= w_grant;
                    end
                end
                EXEC: begin
                    r_q   <= w_aluQ;
                    r_err <= w_aluErr;
                end
                RESP: begin
                    // The requester just served yields priority to the other one.
                    if (bus.rsp_ready) begin
                        r_prio <= ~r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.rsp_valid  = (r_state == RESP) && !rst;
    assign bus.rsp_id     = rst ? 1'b0 : r_id;
    assign bus.rsp_q      = rst ? '0 : r_q;
    assign bus.rsp_err    = rst ? 1'b0 : r_err;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester k presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1 each  requester k's operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  N each  operands.
REQ-007 SHALL have ports req0_sel/req1_sel  input  3 each  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 nor.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-011 SHALL have port rsp_q  output  N+1  result word.
REQ-012 SHALL have port rsp_err  output  1  set when the operation was div with B = 0.

Function
REQ-013 SHALL share one ALU between two requesters through an FSM with states IDLE, EXEC, RESP.
REQ-014 In IDLE, reqK_ready SHALL be 1 only for the granted requester; grant = sole valid requester, or the priority holder if both valid; no grant if neither valid.
REQ-015 reqK_ready SHALL be 0 in EXEC and RESP; req_ready may depend combinationally on req_valid, never the reverse.
REQ-016 On handshake (valid & ready) in IDLE, a, b, sel and requester index SHALL be registered and state SHALL go to EXEC.
REQ-017 In EXEC, the ALU SHALL be driven from the registered operands with en = 1; its output SHALL be captured into rsp_q; state SHALL go to RESP.
REQ-018 Outside EXEC the ALU en SHALL be 0.
REQ-019 Div with B = 0 SHALL capture rsp_q = 0 and rsp_err = 1; every other case SHALL capture rsp_err = 0.
REQ-020 In RESP, rsp_valid SHALL be 1 and rsp_q, rsp_id, rsp_err SHALL stay stable until rsp_ready = 1.
REQ-021 On rsp_valid & rsp_ready, state SHALL go to IDLE and priority SHALL pass to the requester not served.
REQ-022 Latency SHALL be: handshake in cycle t gives rsp_valid in cycle t+2; minimum issue interval is 3 cycles with rsp_ready held high.
REQ-023 Back-to-back IDLE re-grant SHALL not occur in the same cycle as the response handshake.
REQ-024 Arithmetic SHALL follow the ALU: results truncate to N bits and rsp_q[N] = 0; sub wraps modulo 2^N; mul keeps the low N bits; div is unsigned integer quotient.

Reset
REQ-025 rst = 1 at a clock edge SHALL force state IDLE and priority to requester 0.
REQ-026 rst = 1 SHALL force rsp_valid = 0, rsp_q = 0, rsp_id = 0, rsp_err = 0 and both req_ready = 0 during reset.
REQ-027 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight operation with no response emitted.

Structure
REQ-028 Package alu_arb_pkg SHALL hold the state enum (IDLE, EXEC, RESP) and the opcode constants (OP_ADD..OP_NOR, 3 bits).
REQ-029 The block SHALL instantiate exactly one ALU sub-module, named ALU, with parameter n = N.
REQ-030 All registers SHALL sit in one always_ff, and next-state/grant logic in one always_comb.

Verification
REQ-031 Reset test: hold rst 2 cycles with both valids high -> rsp_valid = 0, both readies 0, then after release req0 granted first.
REQ-032 Single op: req0 a = 8'd200, b = 8'd100, sel = 000 -> rsp_q = 9'h02C (wrap), rsp_id = 0, rsp_err = 0, rsp_valid exactly 2 cycles after handshake.
REQ-033 Contention: both valid continuously, rsp_ready = 1; req0 sub 5-7, req1 mul 16*16 -> grants alternate 0,1,0,1; results 9'h0FE and 9'h000.
REQ-034 Div by zero: req1 a = 8'd9, b = 0, sel = 011 -> rsp_q = 0, rsp_err = 1, rsp_id = 1; next div 9/2 -> rsp_q = 4, rsp_err = 0.
REQ-035 Backpressure: rsp_ready = 0 for 5 cycles in RESP -> rsp outputs stable, both readies 0; release -> IDLE next cycle.
REQ-036 Mid-op reset: assert rst in EXEC -> no rsp_valid ever seen for that op; priority back to requester 0.
